// File: rtl/neuron_feeder.sv
// neuron_feeder: assembles a serial activation stream into 8-slot frames for
// the ReLU neuron and queues its results. Option: NEURON_FEEDER_SELFCHECK_EN.
module neuron_feeder #(
   parameter int RESULT_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic [7:0] D0,
   output logic [7:0] D1,
   output logic [7:0] D2,
   output logic [7:0] D3,
   output logic [7:0] D4,
   output logic [7:0] D5,
   output logic [7:0] D6,
   output logic [7:0] D7,
   input  logic [7:0] Q,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       frame_err,
   output logic       chk_mismatch
);

   localparam int AW = $clog2(RESULT_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_EVAL
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  slot_q [8];
   logic [7:0]  slot_d [8];
   logic [2:0]  idx_q, idx_d;
   logic        ferr_q, ferr_d;

   logic [7:0]  mem_q [RESULT_DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic        empty, full;
   logic        push, pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && out_ready;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      idx_d    = idx_q;
      ferr_d   = ferr_q;
      in_ready = 1'b0;
      push     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_COLLECT;
         end
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               slot_d[idx_q] = in_data;
               idx_d         = idx_q + 3'd1;
               if (idx_q == 3'd7 && !in_last)
                  ferr_d = 1'b1;
               if (in_last || idx_q == 3'd7)
                  state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            // A same-cycle pop frees the slot this push needs.
            if (!full || pop) begin
               push  = 1'b1;
               idx_d = 3'd0;
               for (int i = 0; i < 8; i++)
                  slot_d[i] = 8'd0;
               state_d = S_COLLECT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         ferr_q  <= 1'b0;
         for (int i = 0; i < 8; i++)
            slot_q[i] <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ferr_q  <= ferr_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push)
         wr_d = wr_q + (AW+1)'(1);
      if (pop)
         rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < RESULT_DEPTH; i++)
            mem_q[i] <= 8'd0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (push)
            mem_q[wr_q[AW-1:0]] <= Q;
      end
   end

   assign out_valid = !empty;
   assign out_data  = empty ? 8'd0 : mem_q[rd_q[AW-1:0]];
   assign frame_err = ferr_q;

   assign D0 = slot_q[0];
   assign D1 = slot_q[1];
   assign D2 = slot_q[2];
   assign D3 = slot_q[3];
   assign D4 = slot_q[4];
   assign D5 = slot_q[5];
   assign D6 = slot_q[6];
   assign D7 = slot_q[7];

`ifdef NEURON_FEEDER_SELFCHECK_EN
   logic [10:0] sum;
   logic [7:0]  expect_res;
   logic        chk_q, chk_d;

   always_comb begin
      sum = '0;
      for (int i = 0; i < 8; i++)
         sum = sum + {{3{slot_q[i][7]}}, slot_q[i]};
      expect_res = sum[10] ? 8'd0 : sum[9:2];
      chk_d      = chk_q;
      if (push && (Q != expect_res))
         chk_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chk_q <= 1'b0;
      else
         chk_q <= chk_d;
   end

   assign chk_mismatch = chk_q;
`else
   assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: vector table, stall/reset sequences and a
// randomized stream checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_neuron_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, frame_err, chk_mismatch;
   logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7;
   logic [7:0] Q, out_data;

   logic       q_force = 1'b0;
   logic [7:0] q_force_val = 8'd0;
   int         nchk = 0;
   int         nerr = 0;
   bit         mon_en = 1'b0;
   bit         rand_or = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] dv [8];
   int         qsum;

   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  n;
      logic        last;
      logic [7:0]  res;
      logic        ferr;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   neuron_feeder #(.RESULT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3),
      .D4(D4), .D5(D5), .D6(D6), .D7(D7),
      .Q(Q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data),
      .frame_err(frame_err), .chk_mismatch(chk_mismatch)
   );

   assign dv[0] = D0;
   assign dv[1] = D1;
   assign dv[2] = D2;
   assign dv[3] = D3;
   assign dv[4] = D4;
   assign dv[5] = D5;
   assign dv[6] = D6;
   assign dv[7] = D7;

   function automatic logic [7:0] relu8(input int s);
      return (s < 0) ? 8'd0 : 8'(s / 4);
   endfunction

   // Stand-in for the neuron: ReLU of the signed sum, scaled by 1/4.
   always_comb begin
      qsum = 0;
      for (int i = 0; i < 8; i++)
         qsum = qsum + int'($signed(dv[i]));
      Q = q_force ? q_force_val : relu8(qsum);
   end

   function automatic logic [7:0] model(input logic [63:0] b, input int n);
      int s;
      logic [7:0] x;
      s = 0;
      for (int i = 0; i < n; i++) begin
         x = b[8*i +: 8];
         s = s + int'($signed(x));
      end
      return relu8(s);
   endfunction

   function automatic logic [63:0] frame_mask(input logic [63:0] b, input int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++)
         r[8*i +: 8] = b[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL mon_extra: got result %0h, expected none", out_data);
         end else begin
            chk("mon_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
      @(posedge clk);
      #1;
      if (rand_or)
         out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && t < 500) begin
         step();
         t++;
      end
      if (t >= 500) begin
         nchk++;
         nerr++;
         $display("FAIL in_ready_timeout: got 0 for %0d cycles, expected 1", t);
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] b, input int n, input bit last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0)
            step();
         push_byte(b[8*i +: 8], 1'((i == n - 1) && last));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] b;
      logic [7:0]  res [5];
      int          n, t;
      bit          last;
      logic        exp_chk;

      tbl[0] = '{64'h0807060504030201, 4'd8, 1'b1, 8'd9,   1'b0};
      tbl[1] = '{64'h8080808080808080, 4'd8, 1'b1, 8'h00,  1'b0};
      tbl[2] = '{64'h7F7F7F7F7F7F7F7F, 4'd8, 1'b1, 8'hFE,  1'b0};
      tbl[3] = '{64'h00000000001E140A, 4'd3, 1'b1, 8'd15,  1'b0};
      tbl[4] = '{64'h0807060504030201, 4'd8, 1'b0, 8'd9,   1'b1};
      tbl[5] = '{64'h0000000002646464, 4'd4, 1'b1, 8'd75,  1'b1};
      tbl[6] = '{64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b1, 8'h00,  1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_chk", 64'(chk_mismatch), 64'd0);
      chk("rst_D", {dv[7], dv[6], dv[5], dv[4], dv[3], dv[2], dv[1], dv[0]}, 64'd0);
      rst_n = 1'b1;
      chk("rel_in_ready_0", 64'(in_ready), 64'd0);
      step();
      chk("rel_in_ready_1", 64'(in_ready), 64'd1);

      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         send_frame(tbl[k].bytes, int'(tbl[k].n), tbl[k].last, 1'b0);
         chk("eval_in_ready", 64'(in_ready), 64'd0);
         chk("eval_out_valid", 64'(out_valid), 64'd0);
         chk("eval_D", {dv[7], dv[6], dv[5], dv[4], dv[3], dv[2], dv[1], dv[0]},
             frame_mask(tbl[k].bytes, int'(tbl[k].n)));
         step();
         chk("lat_out_valid", 64'(out_valid), 64'd1);
         chk("tbl_out_data", 64'(out_data), 64'(tbl[k].res));
         chk("tbl_frame_err", 64'(frame_err), 64'(tbl[k].ferr));
      end
      step();

`ifdef NEURON_FEEDER_SELFCHECK_EN
      exp_chk = 1'b1;
`else
      exp_chk = 1'b0;
`endif
      q_force     = 1'b1;
      q_force_val = 8'h55;
      send_frame(64'h0807060504030201, 8, 1'b1, 1'b0);
      step();
      chk("force_out_data", 64'(out_data), 64'h55);
      chk("force_chk", 64'(chk_mismatch), 64'(exp_chk));
      q_force = 1'b0;
      step();

      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         b = {8{8'(k + 1)}};
         res[k] = model(b, 8);
         send_frame(b, 8, 1'b1, 1'b0);
      end
      repeat (3) step();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("drain_valid", 64'(out_valid), 64'd1);
         chk("drain_data", 64'(out_data), 64'(res[k]));
         if (k == 1)
            chk("unstall_in_ready", 64'(in_ready), 64'd1);
         step();
      end
      chk("drain_empty", 64'(out_valid), 64'd0);

      mon_en  = 1'b1;
      rand_or = 1'b1;
      for (int f = 0; f < 40; f++) begin
         n = int'($urandom_range(1, 8));
         b = {$urandom, $urandom};
         last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         exp_q.push_back(model(b, n));
         send_frame(b, n, last, 1'b1);
      end
      rand_or   = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (exp_q.size() > 0 && t < 400) begin
         step();
         t++;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      step();
      chk("rand_no_extra", 64'(out_valid), 64'd0);
      chk("rand_frame_err", 64'(frame_err), 64'd1);
      mon_en = 1'b0;

      out_ready = 1'b0;
      send_frame(64'h0807060504030201, 8, 1'b1, 1'b0);
      send_frame(64'h0404040404040404, 8, 1'b1, 1'b0);
      send_frame(64'h0000000000030201, 3, 1'b0, 1'b0);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_data", 64'(out_data), 64'd0);
      chk("mid_rst_frame_err", 64'(frame_err), 64'd0);
      chk("mid_rst_chk", 64'(chk_mismatch), 64'd0);
      chk("mid_rst_D", {dv[7], dv[6], dv[5], dv[4], dv[3], dv[2], dv[1], dv[0]}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rel2_in_ready_0", 64'(in_ready), 64'd0);
      step();
      chk("rel2_in_ready_1", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send_frame(64'h0404040404040404, 8, 1'b1, 1'b0);
      step();
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_data", 64'(out_data), 64'd8);
      step();
      chk("post_rst_empty", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Stream-side driver for the 8-input ReLU neuron datapath.
- Accepts signed 8-bit activations one per handshake and assembles them into an 8-element frame.
- Drives the frame onto the neuron's parallel `D0`–`D7` inputs and samples the neuron's 8-bit `Q` output.
- Queues results in a small output FIFO behind a valid/ready port.
- Sits between the serial activation stream and the combinational neuron, and is the only block that drives the neuron.

## Interface
- `RESULT_DEPTH`, 4: output FIFO depth in results; a power of two, at least 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an activation byte is offered.
- `in_ready` output 1: the feeder accepts a byte this cycle.
- `in_data` input 8: signed activation (two's complement).
- `in_last` input 1: qualifies the byte as the final one of its frame.
- `D0`–`D7` output 8 each: registered frame slots driven to the neuron; `D0` is the first byte of the frame.
- `Q` input 8: neuron result, combinational from `D0`–`D7`.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: downstream takes the head result.
- `out_data` output 8: FIFO head result.
- `frame_err` output 1: sticky; set when the 8th byte arrives without `in_last`.
- `chk_mismatch` output 1: sticky; set on a self-check failure (see Configuration).

## Operation
- **State machine**: IDLE → COLLECT → EVAL → COLLECT.
- **IDLE**:
  - Entered only from reset.
  - Moves to COLLECT on the first clock after `rst_n` rises.
- **COLLECT**:
  - `in_ready` = 1.
  - On each handshake (`in_valid` & `in_ready`), `in_data` is written to slot `idx`, where `idx` is a 3-bit counter starting at 0, and `idx` increments.
  - `in_last` with `idx` < 7 is a short frame: remaining slots hold 0, which they already hold after the previous clear, and the state moves to EVAL.
  - A handshake at `idx` = 7 always closes the frame and moves to EVAL.
  - If that 7th-index byte arrives without `in_last`, `frame_err` is set.
- **EVAL**:
  - `in_ready` = 0 and `D0`–`D7` are stable.
  - If the FIFO is not full, `Q` is pushed, all slots clear to 0, `idx` resets to 0, and the state returns to COLLECT.
  - If the FIFO is full, the state stays in EVAL until a pop frees a slot.
- **FIFO**:
  - Holds `RESULT_DEPTH` entries, in order.
  - Pop on `out_valid` & `out_ready`.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot the push uses.
  - `out_data` is the head entry and is held stable while `out_valid` & !`out_ready`.
- **Arithmetic**: none inside the feeder, unless the self-check is compiled in.
- **Sticky flags**: `frame_err` and `chk_mismatch` clear only on reset.

## Timing
- **Reset values**:
  - `in_ready` = 0 and state = IDLE.
  - `D0`–`D7` = 0, `idx` = 0.
  - FIFO empty, so `out_valid` = 0; `out_data` = 0.
  - `frame_err` = 0, `chk_mismatch` = 0.
- Reset takes effect immediately when asserted, mid-frame or mid-stall.
  - A partial frame and all queued results are discarded.
  - No result is emitted for a partial frame.
- `in_ready` first goes high one cycle after `rst_n` deasserts.
- **Full frame**: 8 accepting cycles plus 1 EVAL cycle, so the best case is 9 cycles per frame.
- The final-byte handshake at edge t updates the last slot, so `D0`–`D7` show the full frame during cycle t+1, which is EVAL.
- `Q` is sampled at the end of EVAL.
- `out_valid` rises the cycle after the push, when the FIFO was previously empty.
- **Latency**: 2 cycles from the final-byte handshake edge to `out_valid`.
- **Short frame**: the same cycle timing, counted from the `in_last` byte.

## Configuration
- **Macro**: `NEURON_FEEDER_SELFCHECK_EN`.
- **Defined**:
  - In EVAL, the feeder computes an 11-bit signed sum of the eight sign-extended slots.
  - Expected value = 0 when the sum is negative (bit 10 set), otherwise sum[9:2].
  - `chk_mismatch` is set on any EVAL push cycle where `Q` ≠ expected.
  - The pushed value is always `Q`.
- **Undefined**: no adder is built; `chk_mismatch` is tied to 0.

## Test plan
- Bytes 1,2,…,8 with `in_last` on the 8th, `out_ready` = 1:
  - `D0`–`D7` = 1…8 in EVAL.
  - `out_data` = 9 (36>>2).
  - `out_valid` 2 cycles after the last handshake; `frame_err` = 0.
- Eight bytes 0x80 → `out_data` = 0x00. Eight bytes 0x7F → `out_data` = 0xFE (1016>>2).
- Short frame 10, 20, 30 with `in_last` on 30:
  - `D3`–`D7` = 0 in EVAL; `out_data` = 15.
  - A following 8-byte frame without `in_last` → result still emitted, `frame_err` = 1 and stays 1.
- `out_ready` = 0 with 5 frames sent at `RESULT_DEPTH` = 4:
  - 4 results held; the 5th frame stalls in EVAL with `in_ready` = 0.
  - Raise `out_ready` → 5 results emerge in order, with no loss or duplication.
  - A pop and a push coincide on the full FIFO.
- Assert `rst_n` = 0 after 3 bytes of a frame, with 2 results queued:
  - All outputs take their reset values immediately; `in_ready` = 1 one cycle after release.
  - The next frame 4×8 (eight 4s) yields `out_data` = 8.
- With `NEURON_FEEDER_SELFCHECK_EN` defined, force `Q` = 0x55 for frame 1…8 → `chk_mismatch` = 1 and `out_data` = 0x55. Without the macro, `chk_mismatch` stays 0.
